// File: rtl/int_ctrl.sv
// Eight-source vectored interrupt controller: rising-edge latching, fixed priority
// (source 0 highest), masking and a single-level service state released by iret.
//
//   state   | meaning
//   IDLE    | no handler running; may take the highest-priority enabled pending source
//   SERVICE | handler for cur_id running; waits for iret on an active instruction cycle
module int_ctrl #(
  parameter logic [15:0] VEC_BASE  = 16'h0020,
  parameter int          VEC_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  irq_src,
  input  logic        int_en,
  input  logic        insn_ce,
  input  logic        iret_detected,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_ad,
  input  logic [15:0] cfg_din,
  output logic [15:0] cfg_dout,
  output logic        irq_take,
  output logic [15:0] irq_vector
);

  typedef enum logic {IDLE = 1'b0, SERVICE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  pend_q, pend_d;
  logic [7:0]  prev_q;
  logic [2:0]  cur_id_q, cur_id_d;

  logic [7:0]  req;
  logic [2:0]  sel_id;
  logic        busy;
  logic [7:0]  pend_set, pend_clr;
  logic        unused_cfg_din;

  assign unused_cfg_din = ^cfg_din[15:8];

  assign req = pend_q & mask_q;

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    sel_id = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) sel_id = 3'(i);
    end
  end

  assign irq_vector = VEC_BASE + (16'(sel_id) << VEC_SHIFT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (irq_take) state_d = SERVICE;
      SERVICE: if (iret_detected && insn_ce) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy     = (state_q == SERVICE);
    irq_take = (state_q == IDLE) && int_en && insn_ce && (|req);
  end

  // Set terms are applied after clear terms so a coincident set always wins.
  always_comb begin
    pend_set = (irq_src & ~prev_q);
    pend_clr = irq_take ? (8'h01 << sel_id) : 8'h00;
    mask_d   = mask_q;
    if (cfg_we) begin
      case (cfg_ad)
        2'd0:    mask_d   = cfg_din[7:0];
        2'd1:    pend_clr = pend_clr | cfg_din[7:0];
        2'd3:    pend_set = pend_set | cfg_din[7:0];
        default: ;
      endcase
    end
    pend_d   = (pend_q & ~pend_clr) | pend_set;
    cur_id_d = irq_take ? sel_id : cur_id_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q   <= 8'h00;
      pend_q   <= 8'h00;
      prev_q   <= 8'h00;
      cur_id_q <= 3'd0;
    end else begin
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      prev_q   <= irq_src;
      cur_id_q <= cur_id_d;
    end
  end

  always_comb begin
    cfg_dout = 16'h0000;
    case (cfg_ad)
      2'd0:    cfg_dout = {8'h00, mask_q};
      2'd1:    cfg_dout = {8'h00, pend_q};
      2'd2:    cfg_dout = {7'b0, busy, 5'b0, cur_id_q};
      default: cfg_dout = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: linear scenario steps with hand-computed expectations.
`timescale 1ns/1ps
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq_src;
  logic        int_en, insn_ce, iret_detected, cfg_we;
  logic [1:0]  cfg_ad;
  logic [15:0] cfg_din, cfg_dout, irq_vector;
  logic        irq_take;

  int n_vec = 0;
  int n_err = 0;

  int_ctrl dut (
    .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .int_en(int_en), .insn_ce(insn_ce),
    .iret_detected(iret_detected), .cfg_we(cfg_we), .cfg_ad(cfg_ad), .cfg_din(cfg_din),
    .cfg_dout(cfg_dout), .irq_take(irq_take), .irq_vector(irq_vector)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [1:0] ad, input logic [15:0] exp);
    cfg_ad = ad;
    #0.5;
    chk(tag, cfg_dout, exp);
  endtask

  task automatic take_chk(input string tag, input logic exp_take, input logic [15:0] exp_vec);
    #0.5;
    chk({tag, "_take"}, {15'b0, irq_take}, {15'b0, exp_take});
    if (exp_take) chk({tag, "_vec"}, irq_vector, exp_vec);
  endtask

  task automatic wr(input logic [1:0] ad, input logic [7:0] d);
    cfg_we = 1'b1; cfg_ad = ad; cfg_din = {8'hA5, d};
    tick();
    cfg_we = 1'b0; cfg_din = 16'h0000;
  endtask

  task automatic iret();
    iret_detected = 1'b1;
    tick();
    iret_detected = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq_src = 8'h00; int_en = 1'b0; insn_ce = 1'b0;
    iret_detected = 1'b0; cfg_we = 1'b0; cfg_ad = 2'd0; cfg_din = 16'h0000;
    #2;
    chk("rst_take", {15'b0, irq_take}, 16'h0000);
    rd("rst_mask", 2'd0, 16'h0000);
    rd("rst_pend", 2'd1, 16'h0000);
    rd("rst_stat", 2'd2, 16'h0000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    tick();
    int_en = 1'b1; insn_ce = 1'b1;

    // Single source, exact one-cycle take
    wr(2'd0, 8'h04);
    irq_src = 8'h04; tick(); irq_src = 8'h00;
    take_chk("s37", 1'b1, 16'h0028);
    tick();
    take_chk("s37_once", 1'b0, 16'h0000);
    rd("s37_stat", 2'd2, 16'h0102);
    rd("s37_pend", 2'd1, 16'h0000);
    rd("s37_swtrig_rd", 2'd3, 16'h0000);
    iret();
    rd("s37_hold_id", 2'd2, 16'h0002);

    // Priority between simultaneous edges
    wr(2'd0, 8'hFF);
    irq_src = 8'h22; tick(); irq_src = 8'h00;
    take_chk("s38_first", 1'b1, 16'h0024);
    tick();
    take_chk("s38_svc", 1'b0, 16'h0000);
    rd("s38_pend", 2'd1, 16'h0020);
    iret();
    take_chk("s38_second", 1'b1, 16'h0034);
    tick();
    rd("s38_stat", 2'd2, 16'h0105);
    iret();

    // Higher-priority edge during service waits for iret and int_en
    irq_src = 8'h08; tick(); irq_src = 8'h00;
    take_chk("s39_src3", 1'b1, 16'h002C);
    tick();
    irq_src = 8'h01; tick(); irq_src = 8'h00;
    take_chk("s39_blocked", 1'b0, 16'h0000);
    rd("s39_pend", 2'd1, 16'h0001);
    tick();
    take_chk("s39_blocked2", 1'b0, 16'h0000);
    int_en = 1'b0;
    iret();
    take_chk("s39_inten0", 1'b0, 16'h0000);
    int_en = 1'b1;
    take_chk("s39_take", 1'b1, 16'h0020);
    tick();
    iret();
    iret();
    rd("s39_idle_iret", 2'd2, 16'h0000);

    // Masked source keeps latching; W1C before unmask drops it
    wr(2'd0, 8'h00);
    irq_src = 8'h40; tick(); irq_src = 8'h00;
    take_chk("s40_masked", 1'b0, 16'h0000);
    rd("s40_pend", 2'd1, 16'h0040);
    wr(2'd0, 8'h40);
    take_chk("s40_unmask", 1'b1, 16'h0038);
    tick();
    iret();
    wr(2'd0, 8'h00);
    irq_src = 8'h40; tick(); irq_src = 8'h00;
    wr(2'd1, 8'h40);
    rd("s40_w1c", 2'd1, 16'h0000);
    wr(2'd0, 8'h40);
    take_chk("s40_no_take", 1'b0, 16'h0000);

    // Stall defers the take without losing it
    insn_ce = 1'b0;
    irq_src = 8'h40; tick(); irq_src = 8'h00;
    take_chk("s41_stall1", 1'b0, 16'h0000);
    tick();
    take_chk("s41_stall2", 1'b0, 16'h0000);
    tick();
    take_chk("s41_stall3", 1'b0, 16'h0000);
    insn_ce = 1'b1;
    take_chk("s41_take", 1'b1, 16'h0038);
    tick();

    // Async reset mid-service
    wr(2'd3, 8'h10);
    rd("s42_pend_pre", 2'd1, 16'h0010);
    rd("s42_stat_pre", 2'd2, 16'h0106);
    irq_src = 8'h01;
    @(negedge clk);
    rst_n = 1'b0;
    #0.5;
    chk("s42_take", {15'b0, irq_take}, 16'h0000);
    rd("s42_stat", 2'd2, 16'h0000);
    rd("s42_pend", 2'd1, 16'h0000);
    rd("s42_mask", 2'd0, 16'h0000);
    #2.5;
    rst_n = 1'b1;
    tick();

    // Source high across reset release registers an edge
    rd("r36_pend", 2'd1, 16'h0001);
    irq_src = 8'h00;
    wr(2'd0, 8'h01);
    take_chk("r36_take", 1'b1, 16'h0020);
    tick();
    iret();

    // Set wins over a coincident W1C on the same bit
    irq_src = 8'h04;
    wr(2'd1, 8'h04);
    irq_src = 8'h00;
    rd("set_wins", 2'd1, 16'h0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL have parameter VEC_BASE, default 16'h0020: byte address of the vector for source 0.
REQ-002 The block SHALL have parameter VEC_SHIFT, default 2: log2 of the vector stride in bytes (4 bytes, i.e. an IMM+JAL pair).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port irq_src, input, 8 bits: request lines, synchronous to clk, rising-edge sensitive; bit 0 has highest priority.
REQ-006 The block SHALL have port int_en, input, 1 bit: the CPU may accept an interrupt this cycle.
REQ-007 The block SHALL have port insn_ce, input, 1 bit: CPU instruction clock enable; 0 means the CPU is stalled.
REQ-008 The block SHALL have port iret_detected, input, 1 bit: the CPU is executing iret (JAL r14,r14,#0).
REQ-009 The block SHALL have port cfg_we, input, 1 bit: configuration write strobe.
REQ-010 The block SHALL have port cfg_ad, input, 2 bits: configuration register select.
REQ-011 The block SHALL have port cfg_din, input, 16 bits: configuration write data; only bits [7:0] are used.
REQ-012 The block SHALL have port cfg_dout, output, 16 bits: configuration read data, combinational from cfg_ad.
REQ-013 The block SHALL have port irq_take, output, 1 bit: the CPU redirects to irq_vector this cycle.
REQ-014 The block SHALL have port irq_vector, output, 16 bits: handler address for the selected source.

Function
REQ-015 Edge detect SHALL work as follows: irq_prev <= irq_src every cycle; pending[i] is set on any cycle where irq_src[i] & ~irq_prev[i].
REQ-016 Config registers SHALL be: ad0 MASK (RW, 1=enabled); ad1 PENDING (read returns pending, write-1-to-clear); ad2 STATUS (RO, {7'b0, busy, 5'b0, cur_id[2:0]}); ad3 SWTRIG (write-1 sets pending; reads 0).
REQ-017 Unused cfg_dout bits SHALL read 0.
REQ-018 The FSM SHALL have two states: IDLE and SERVICE.
REQ-019 The busy bit SHALL be 1 if and only if the state is SERVICE.
REQ-020 Request selection SHALL be req = pending & MASK, with sel_id = index of the lowest set bit of req.
REQ-021 irq_take SHALL be combinational, equal to (state==IDLE) & int_en & insn_ce & |req.
REQ-022 irq_take SHALL never be high in SERVICE and SHALL never be high for two consecutive cycles.
REQ-023 irq_vector SHALL equal VEC_BASE + (sel_id << VEC_SHIFT), combinational; its value is don't-care when irq_take=0, but it SHALL still be driven from sel_id.
REQ-024 On a clock edge with irq_take=1: state -> SERVICE; cur_id <= sel_id; pending[sel_id] cleared.
REQ-025 In SERVICE, iret_detected & insn_ce SHALL move the state to IDLE on the next edge.
REQ-026 cur_id SHALL hold its value after return to IDLE.
REQ-027 iret_detected in IDLE SHALL be ignored, with no state change.
REQ-028 Simultaneous set and clear of the same pending bit (new edge, SWTRIG, take-clear, or W1C) SHALL resolve so that set wins and the bit ends at 1.
REQ-029 Pending bits of masked sources SHALL keep latching; unmasking a source with a pending bit makes it eligible in that same cycle.
REQ-030 A new edge on a source while that source is in service SHALL set pending; it is taken after iret.
REQ-031 int_en=0 or insn_ce=0 SHALL only defer a take; no request is lost.
REQ-032 A config write and an irq_take on the same edge SHALL both take effect; selection uses the pre-edge MASK and pending values.

Reset
REQ-033 On rst_n=0, asynchronously: state=IDLE, MASK=8'h00, pending=8'h00, irq_prev=8'h00, cur_id=0.
REQ-034 During reset, irq_take=0, and cfg_dout reflects the reset values.
REQ-035 Reset asserted during SERVICE SHALL abandon service; no iret is required afterwards.
REQ-036 Sources already high when reset deasserts SHALL register an edge on the first clock (irq_prev=0).

Verification
REQ-037 Scenario: MASK=8'h04, pulse irq_src[2], int_en=1, insn_ce=1 -> irq_take for exactly 1 cycle with irq_vector=16'h0028; STATUS then reads 16'h0102; PENDING reads 0.
REQ-038 Scenario: MASK=8'hFF, edges on sources 5 and 1 in the same cycle -> first take has vector 16'h0024; after iret, the second take has vector 16'h0034.
REQ-039 Scenario: in SERVICE for source 3, an edge on source 0 -> no irq_take until an iret cycle; then a take with vector 16'h0020 occurs on the first IDLE cycle with int_en=1.
REQ-040 Scenario: MASK=0, edge on source 6 -> no take and PENDING=16'h0040; write MASK=8'h40 -> take with vector 16'h0038; alternatively, writing PENDING=16'h0040 before unmasking -> no take.
REQ-041 Scenario: request pending with int_en=1 but insn_ce=0 for 3 cycles -> irq_take=0 throughout; take occurs on the first cycle insn_ce=1.
REQ-042 Scenario: rst_n low for one half-cycle mid-SERVICE with pending=8'h10 -> STATUS=0, PENDING=0, irq_take=0 immediately, without waiting for a clock edge.
